// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle for axi_lite_regbank: the five channels, with the
// signal names used on the register bank's bus port.
interface axi_lite_regbank_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;

  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;

  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;

  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;

  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: NREGS x 32-bit software registers with per-register
// write/read strobes. Define REGBANK_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi_lite_regbank #(
  parameter int                   NREGS   = 16,
  parameter int                   ADDR_W  = 6,
  parameter logic [NREGS-1:0]     RO_MASK = '0,
  parameter logic [NREGS*32-1:0]  RST_VAL = '0
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  axi_lite_regbank_if.slave       s_axi,
  output logic [NREGS*32-1:0]     slv_reg,
  input  logic [NREGS*32-1:0]     slv_read,
  output logic [NREGS-1:0]        wr_pulse,
  output logic [NREGS-1:0]        rd_pulse
);

  localparam int               IDX_W     = ADDR_W - 2;
  localparam logic [IDX_W:0]   NREGS_CMP = (IDX_W + 1)'(NREGS);
  localparam logic [1:0]       RESP_OKAY = 2'b00;
`ifdef REGBANK_SLVERR_EN
  localparam logic [1:0]       RESP_OOR  = 2'b10;
`else
  localparam logic [1:0]       RESP_OOR  = 2'b00;
`endif

  // r_active holds the ready outputs low until the first edge after reset release.
  logic                  r_active;
  logic                  r_aw_full;
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_w_full;
  logic [31:0]           r_w_data;
  logic [3:0]            r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;
  logic [NREGS*32-1:0]   r_slv;
  logic [NREGS-1:0]      r_wr_pulse;
  logic [NREGS-1:0]      r_rd_pulse;

  logic                  w_awready;
  logic                  w_wready;
  logic                  w_arready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_aw_in_range;
  logic                  w_ar_in_range;
  logic [NREGS-1:0]      w_wr_hit;
  logic [NREGS-1:0]      w_rd_hit;
  logic [NREGS-1:0]      w_wr_en;
  logic [31:0]           w_rd_word;
  logic                  w_unused;

  assign w_awready = r_active && !r_aw_full;
  assign w_wready  = r_active && !r_w_full;
  assign w_arready = r_active && (!r_rvalid || s_axi.S_AXI_RREADY);

  assign w_aw_hs   = s_axi.S_AXI_AWVALID && w_awready;
  assign w_w_hs    = s_axi.S_AXI_WVALID  && w_wready;
  assign w_ar_hs   = s_axi.S_AXI_ARVALID && w_arready;
  // A pending response blocks the next commit so BVALID never has to queue.
  assign w_commit  = r_aw_full && r_w_full && !r_bvalid;

  assign w_ar_idx      = s_axi.S_AXI_ARADDR[ADDR_W-1:2];
  assign w_aw_in_range = ({1'b0, r_aw_idx} < NREGS_CMP);
  assign w_ar_in_range = ({1'b0, w_ar_idx} < NREGS_CMP);

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_decode
      assign w_wr_hit[gi] = (r_aw_idx == IDX_W'(gi));
      assign w_rd_hit[gi] = (w_ar_idx == IDX_W'(gi));
      assign w_wr_en[gi]  = w_commit && w_wr_hit[gi] && !RO_MASK[gi];
    end
  endgenerate

  // Out-of-range indices match no register, so the mux yields zero for them.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (w_ar_idx == IDX_W'(i)) begin
        w_rd_word = slv_read[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axi.S_AXI_AWADDR[ADDR_W-1:2];
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= s_axi.S_AXI_WDATA;
        r_w_strb <= s_axi.S_AXI_WSTRB;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_commit ? w_wr_hit : '0;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_in_range ? RESP_OKAY : RESP_OOR;
      end else if (s_axi.S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_slv <= RST_VAL;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wr_en[i] && r_w_strb[b]) begin
            r_slv[i*32 + b*8 +: 8] <= r_w_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rd_pulse <= '0;
    end else begin
      r_rd_pulse <= w_ar_hs ? w_rd_hit : '0;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_word;
        r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_OOR;
      end else if (s_axi.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = w_awready;
  assign s_axi.S_AXI_WREADY  = w_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = w_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

  assign slv_reg  = r_slv;
  assign wr_pulse = r_wr_pulse;
  assign rd_pulse = r_rd_pulse;

  // Protection bits and byte offsets carry no meaning for a word register bank.
  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank (NREGS=8, register 1 read-only); expected
// out-of-range response follows REGBANK_SLVERR_EN.
module tb_axi_lite_regbank;

  localparam int NREGS = 8;
  localparam int ADDR_W = 6;
  localparam logic [NREGS-1:0] TB_RO = 8'h02;
  localparam logic [NREGS*32-1:0] TB_RST = {32'h77770007, 32'h0, 32'h0, 32'h0,
                                            32'h0, 32'h000000A5, 32'hCAFE0001, 32'h0};
`ifdef REGBANK_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic clk;
  logic rst_n;
  logic [NREGS*32-1:0] slv_reg;
  logic [NREGS*32-1:0] slv_read_tb;
  logic [NREGS*32-1:0] slv_read_mux;
  logic loopback;
  logic [NREGS-1:0] wr_pulse;
  logic [NREGS-1:0] rd_pulse;
  logic [NREGS*32-1:0] exp_reg;
  int checks;
  int errors;

  axi_lite_regbank_if #(.ADDR_W(ADDR_W)) s_axi ();

  assign slv_read_mux = loopback ? slv_reg : slv_read_tb;

  axi_lite_regbank #(
    .NREGS(NREGS), .ADDR_W(ADDR_W), .RO_MASK(TB_RO), .RST_VAL(TB_RST)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi(s_axi),
    .slv_reg(slv_reg),
    .slv_read(slv_read_mux),
    .wr_pulse(wr_pulse),
    .rd_pulse(rd_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

  // Issues AW and W together, waits for the response and captures wr_pulse at BVALID.
  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] strb,
                          output bit ok, output logic [1:0] bresp, output logic [NREGS-1:0] pulse);
    bit aw_done;
    bit w_done;
    aw_done = 0; w_done = 0; ok = 0; bresp = 2'bxx; pulse = 'x;
    s_axi.S_AXI_AWADDR = a; s_axi.S_AXI_WDATA = d; s_axi.S_AXI_WSTRB = strb;
    s_axi.S_AXI_AWVALID = 1'b1; s_axi.S_AXI_WVALID = 1'b1;
    for (int k = 0; k < 20 && !(aw_done && w_done); k++) begin
      if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY) aw_done = 1;
      if (s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY) w_done = 1;
      @(negedge clk);
      if (aw_done) s_axi.S_AXI_AWVALID = 1'b0;
      if (w_done) s_axi.S_AXI_WVALID = 1'b0;
    end
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (s_axi.S_AXI_BVALID) begin
        ok = 1; bresp = s_axi.S_AXI_BRESP; pulse = wr_pulse;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      s_axi.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      s_axi.S_AXI_BREADY = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY, s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID} !== 5'b0) begin errors++; $display("FAIL reset_handshake: got %b expected 00000", {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY, s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID}); end
    checks++; if ({s_axi.S_AXI_BRESP, s_axi.S_AXI_RRESP, s_axi.S_AXI_RDATA, wr_pulse, rd_pulse} !== '0) begin errors++; $display("FAIL reset_data: got bresp %b rresp %b rdata %h wrp %h rdp %h expected all 0", s_axi.S_AXI_BRESP, s_axi.S_AXI_RRESP, s_axi.S_AXI_RDATA, wr_pulse, rd_pulse); end
    checks++; if (slv_reg !== TB_RST) begin errors++; $display("FAIL reset_slv_reg: got %h expected %h", slv_reg, TB_RST); end
    rst_n = 1'b1;
    #1;
    checks++; if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY} !== 3'b000) begin errors++; $display("FAIL ready_before_edge: got %b expected 000", {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY}); end
    @(negedge clk);
    checks++; if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY} !== 3'b111) begin errors++; $display("FAIL ready_after_edge: got %b expected 111", {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY}); end
    $display("reset: done");
  endtask

  task automatic test_write_split();
    s_axi.S_AXI_AWADDR = 6'h08; s_axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_AWVALID = 1'b0;
    checks++; if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY} !== 2'b01) begin errors++; $display("FAIL split_aw_held: got aw/w ready %b expected 01", {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY}); end
    repeat (2) @(negedge clk);
    s_axi.S_AXI_WDATA = 32'h12345678; s_axi.S_AXI_WSTRB = 4'hF; s_axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_WVALID = 1'b0;
    checks++; if ({wr_pulse, slv_reg[2*32 +: 32]} !== {8'h00, 32'h000000A5}) begin errors++; $display("FAIL split_pre_commit: got pulse %h reg2 %h expected 00 000000a5", wr_pulse, slv_reg[2*32 +: 32]); end
    @(negedge clk);
    exp_reg[2*32 +: 32] = 32'h12345678;
    checks++; if (slv_reg !== exp_reg) begin errors++; $display("FAIL split_data: got %h expected %h", slv_reg, exp_reg); end
    checks++; if ({wr_pulse, s_axi.S_AXI_BVALID, s_axi.S_AXI_BRESP} !== {8'h04, 1'b1, 2'b00}) begin errors++; $display("FAIL split_resp: got pulse %h bvalid %b bresp %b expected 04 1 00", wr_pulse, s_axi.S_AXI_BVALID, s_axi.S_AXI_BRESP); end
    @(negedge clk);
    checks++; if ({wr_pulse, s_axi.S_AXI_BVALID} !== {8'h00, 1'b1}) begin errors++; $display("FAIL split_pulse_once: got pulse %h bvalid %b expected 00 1", wr_pulse, s_axi.S_AXI_BVALID); end
    s_axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_BREADY = 1'b0;
    checks++; if (s_axi.S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL split_b_done: got bvalid %b expected 0", s_axi.S_AXI_BVALID); end
    $display("write_split: addr 08 data 12345678 done");
  endtask

  task automatic test_strobes();
    bit ok; logic [1:0] br; logic [NREGS-1:0] p;
    logic [5:0] addrs [4] = '{6'h0C, 6'h0C, 6'h0C, 6'h13};
    logic [31:0] datas [4] = '{32'hFFFFFFFF, 32'h11223344, 32'h00000000, 32'h0BADF00D};
    logic [3:0] strbs [4] = '{4'h5, 4'hA, 4'h0, 4'hF};
    logic [31:0] exps [4] = '{32'h00FF00FF, 32'h11FF33FF, 32'h11FF33FF, 32'h0BADF00D};
    int idxs [4] = '{3, 3, 3, 4};
    for (int t = 0; t < 4; t++) begin
      do_write(addrs[t], datas[t], strbs[t], ok, br, p);
      exp_reg[idxs[t]*32 +: 32] = exps[t];
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL strobe_timeout[%0d]: got no BVALID expected response", t); end
      checks++; if ({br, p} !== {2'b00, 8'(1 << idxs[t])}) begin errors++; $display("FAIL strobe_resp[%0d]: got bresp %b pulse %h expected 00 %h", t, br, p, 8'(1 << idxs[t])); end
      checks++; if (slv_reg !== exp_reg) begin errors++; $display("FAIL strobe_data[%0d]: got %h expected %h", t, slv_reg, exp_reg); end
      $display("strobe: addr %h data %h strb %h -> reg%0d %h", addrs[t], datas[t], strbs[t], idxs[t], slv_reg[idxs[t]*32 +: 32]);
    end
  endtask

  task automatic test_read_only_and_oor();
    bit ok; logic [1:0] br; logic [NREGS-1:0] p;
    do_write(6'h04, 32'hAAAA5555, 4'hF, ok, br, p);
    checks++; if ({ok, br, p} !== {1'b1, 2'b00, 8'h02}) begin errors++; $display("FAIL ro_resp: got ok %b bresp %b pulse %h expected 1 00 02", ok, br, p); end
    checks++; if (slv_reg !== exp_reg) begin errors++; $display("FAIL ro_data: got %h expected %h", slv_reg, exp_reg); end
    $display("read_only: addr 04 reg1 %h", slv_reg[32 +: 32]);
    do_write(6'h3C, 32'h5A5A5A5A, 4'hF, ok, br, p);
    checks++; if ({ok, br, p} !== {1'b1, OOR_RESP, 8'h00}) begin errors++; $display("FAIL oor_wr_resp: got ok %b bresp %b pulse %h expected 1 %b 00", ok, br, p, OOR_RESP); end
    checks++; if (slv_reg !== exp_reg) begin errors++; $display("FAIL oor_wr_data: got %h expected %h", slv_reg, exp_reg); end
    $display("oor_write: addr 3c bresp %b", br);
  endtask

  task automatic test_back_to_back();
    slv_read_tb[0*32 +: 32] = 32'hDEADBEEF;
    slv_read_tb[1*32 +: 32] = 32'h76543210;
    s_axi.S_AXI_ARADDR = 6'h00; s_axi.S_AXI_ARVALID = 1'b1; s_axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    checks++; if ({s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA, s_axi.S_AXI_RRESP, rd_pulse} !== {1'b1, 32'hDEADBEEF, 2'b00, 8'h01}) begin errors++; $display("FAIL b2b_first: got rvalid %b rdata %h rresp %b pulse %h expected 1 deadbeef 00 01", s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA, s_axi.S_AXI_RRESP, rd_pulse); end
    checks++; if (s_axi.S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL b2b_arready: got %b expected 1", s_axi.S_AXI_ARREADY); end
    s_axi.S_AXI_ARADDR = 6'h04;
    @(negedge clk);
    s_axi.S_AXI_ARVALID = 1'b0;
    checks++; if ({s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA, rd_pulse} !== {1'b1, 32'h76543210, 8'h02}) begin errors++; $display("FAIL b2b_second: got rvalid %b rdata %h pulse %h expected 1 76543210 02", s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA, rd_pulse); end
    @(negedge clk);
    checks++; if ({s_axi.S_AXI_RVALID, rd_pulse} !== {1'b0, 8'h00}) begin errors++; $display("FAIL b2b_drain: got rvalid %b pulse %h expected 0 00", s_axi.S_AXI_RVALID, rd_pulse); end
    s_axi.S_AXI_ARADDR = 6'h3C; s_axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_ARVALID = 1'b0;
    checks++; if ({s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA, s_axi.S_AXI_RRESP, rd_pulse} !== {1'b1, 32'h0, OOR_RESP, 8'h00}) begin errors++; $display("FAIL oor_read: got rvalid %b rdata %h rresp %b pulse %h expected 1 00000000 %b 00", s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA, s_axi.S_AXI_RRESP, rd_pulse, OOR_RESP); end
    @(negedge clk);
    s_axi.S_AXI_RREADY = 1'b0;
    $display("back_to_back: reads 00,04,3c done");
  endtask

  task automatic test_read_hold();
    slv_read_tb[2*32 +: 32] = 32'h11110000;
    s_axi.S_AXI_ARADDR = 6'h08; s_axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_ARVALID = 1'b0;
    slv_read_tb[2*32 +: 32] = 32'h22220000;
    checks++; if ({s_axi.S_AXI_RVALID, s_axi.S_AXI_ARREADY} !== 2'b10) begin errors++; $display("FAIL hold_arready: got rvalid/arready %b expected 10", {s_axi.S_AXI_RVALID, s_axi.S_AXI_ARREADY}); end
    repeat (2) @(negedge clk);
    checks++; if ({s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA} !== {1'b1, 32'h11110000}) begin errors++; $display("FAIL hold_data: got rvalid %b rdata %h expected 1 11110000", s_axi.S_AXI_RVALID, s_axi.S_AXI_RDATA); end
    s_axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_RREADY = 1'b0;
    checks++; if (s_axi.S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL hold_release: got rvalid %b expected 0", s_axi.S_AXI_RVALID); end
    $display("read_hold: addr 08 data held 11110000");
  endtask

  task automatic test_rw_same();
    loopback = 1'b1;
    s_axi.S_AXI_AWADDR = 6'h10; s_axi.S_AXI_WDATA = 32'h99999999; s_axi.S_AXI_WSTRB = 4'hF;
    s_axi.S_AXI_AWVALID = 1'b1; s_axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0;
    s_axi.S_AXI_ARADDR = 6'h10; s_axi.S_AXI_ARVALID = 1'b1; s_axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_ARVALID = 1'b0;
    exp_reg[4*32 +: 32] = 32'h99999999;
    checks++; if (s_axi.S_AXI_RDATA !== 32'h0BADF00D) begin errors++; $display("FAIL rw_same_rdata: got %h expected 0badf00d", s_axi.S_AXI_RDATA); end
    checks++; if ({slv_reg, wr_pulse, rd_pulse, s_axi.S_AXI_BVALID} !== {exp_reg, 8'h10, 8'h10, 1'b1}) begin errors++; $display("FAIL rw_same_state: got reg %h wrp %h rdp %h bvalid %b expected reg %h 10 10 1", slv_reg, wr_pulse, rd_pulse, s_axi.S_AXI_BVALID, exp_reg); end
    s_axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_BREADY = 1'b0; s_axi.S_AXI_RREADY = 1'b0;
    loopback = 1'b0;
    $display("rw_same: addr 10 read %h wrote 99999999", s_axi.S_AXI_RDATA);
  endtask

  task automatic test_bstall_reset();
    bit stall_ok;
    s_axi.S_AXI_AWADDR = 6'h14; s_axi.S_AXI_WDATA = 32'h00000055; s_axi.S_AXI_WSTRB = 4'hF;
    s_axi.S_AXI_AWVALID = 1'b1; s_axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    exp_reg[5*32 +: 32] = 32'h00000055;
    checks++; if ({s_axi.S_AXI_BVALID, slv_reg} !== {1'b1, exp_reg}) begin errors++; $display("FAIL stall_first: got bvalid %b reg %h expected 1 %h", s_axi.S_AXI_BVALID, slv_reg, exp_reg); end
    s_axi.S_AXI_AWADDR = 6'h18; s_axi.S_AXI_WDATA = 32'h00000066;
    s_axi.S_AXI_AWVALID = 1'b1; s_axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0;
    stall_ok = 1;
    for (int k = 0; k < 10; k++) begin
      if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_BVALID, wr_pulse} !== {3'b001, 8'h00} || slv_reg !== exp_reg) stall_ok = 0;
      @(negedge clk);
    end
    checks++; if (stall_ok !== 1'b1) begin errors++; $display("FAIL stall_hold: second write not held during 10-cycle BREADY low, reg %h expected %h", slv_reg, exp_reg); end
    s_axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_BREADY = 1'b0;
    checks++; if ({s_axi.S_AXI_BVALID, slv_reg} !== {1'b0, exp_reg}) begin errors++; $display("FAIL stall_gap: got bvalid %b reg %h expected 0 %h", s_axi.S_AXI_BVALID, slv_reg, exp_reg); end
    @(negedge clk);
    exp_reg[6*32 +: 32] = 32'h00000066;
    checks++; if ({s_axi.S_AXI_BVALID, wr_pulse, slv_reg} !== {1'b1, 8'h40, exp_reg}) begin errors++; $display("FAIL stall_second: got bvalid %b pulse %h reg %h expected 1 40 %h", s_axi.S_AXI_BVALID, wr_pulse, slv_reg, exp_reg); end
    s_axi.S_AXI_AWADDR = 6'h1C; s_axi.S_AXI_WDATA = 32'h12121212;
    s_axi.S_AXI_AWVALID = 1'b1; s_axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    s_axi.S_AXI_AWVALID = 1'b0; s_axi.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY, s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID, wr_pulse, rd_pulse} !== '0) begin errors++; $display("FAIL midreset_ctrl: got ready/valid %b pulses %h %h expected all 0", {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_ARREADY, s_axi.S_AXI_BVALID, s_axi.S_AXI_RVALID}, wr_pulse, rd_pulse); end
    checks++; if ({s_axi.S_AXI_BRESP, s_axi.S_AXI_RRESP, s_axi.S_AXI_RDATA, slv_reg} !== {36'h0, TB_RST}) begin errors++; $display("FAIL midreset_data: got rdata %h reg %h expected 0 %h", s_axi.S_AXI_RDATA, slv_reg, TB_RST); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_reg = TB_RST;
    repeat (4) @(negedge clk);
    checks++; if ({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_BVALID, wr_pulse, slv_reg} !== {3'b110, 8'h00, exp_reg}) begin errors++; $display("FAIL post_reset_discard: got aw/w/b %b pulse %h reg %h expected 110 00 %h", {s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_BVALID}, wr_pulse, slv_reg, exp_reg); end
    $display("bstall_reset: stalled commit and mid-wait reset done");
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; loopback = 1'b0; slv_read_tb = '0; exp_reg = TB_RST;
    s_axi.S_AXI_AWADDR = '0; s_axi.S_AXI_AWPROT = '0; s_axi.S_AXI_AWVALID = 1'b0;
    s_axi.S_AXI_WDATA = '0; s_axi.S_AXI_WSTRB = '0; s_axi.S_AXI_WVALID = 1'b0;
    s_axi.S_AXI_BREADY = 1'b0;
    s_axi.S_AXI_ARADDR = '0; s_axi.S_AXI_ARPROT = '0; s_axi.S_AXI_ARVALID = 1'b0;
    s_axi.S_AXI_RREADY = 1'b0;
    test_reset();
    test_write_split();
    test_strobes();
    test_read_only_and_oor();
    test_back_to_back();
    test_read_hold();
    test_rw_same();
    test_bstall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank.md
AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 SHALL have parameter NREGS, default 16, number of 32-bit registers (2..256).
REQ-002 SHALL have parameter ADDR_W, default 6, AXI byte-address width; SHALL satisfy 2^(ADDR_W-2) >= NREGS.
REQ-003 SHALL have parameter RO_MASK, default 0 (NREGS bits); bit i=1 makes register i read-only.
REQ-004 SHALL have parameter RST_VAL, default all-zero (NREGS x 32 packed), the reset value of slv_reg.
REQ-005 S_AXI_ACLK  in  1  single clock; all logic on its rising edge.
REQ-006 S_AXI_ARESETN  in  1  asynchronous, active-low reset.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_W/3/1/1  write-address channel; PROT ignored.
REQ-008 S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write-data channel.
REQ-009 S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write-response channel.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_W/3/1/1  read-address channel; PROT ignored.
REQ-011 S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read-data channel.
REQ-012 slv_reg  out  NREGS x 32  registered software-written values.
REQ-013 slv_read  in  NREGS x 32  values returned on reads (user loops back or drives status).
REQ-014 wr_pulse  out  NREGS  one-cycle strobe per register on write commit.
REQ-015 rd_pulse  out  NREGS  one-cycle strobe per register on read acceptance.

Function
REQ-016 Register index SHALL be ADDR[ADDR_W-1:2]; ADDR[1:0] ignored; index >= NREGS is out-of-range.
REQ-017 AW and W SHALL be accepted independently into one-entry holding registers; AWREADY=1 iff AW holder empty, WREADY=1 iff W holder empty.
REQ-018 Write SHALL commit on the first cycle both holders are full and BVALID=0; both holders empty on that edge.
REQ-019 On commit to in-range writable register i, byte lane b of slv_reg[i] SHALL update iff WSTRB[b]=1; WSTRB=0 commits with no data change.
REQ-020 wr_pulse[i] SHALL be 1 for exactly the cycle after commit (aligned with first slv_reg update visibility) for in-range i, including read-only i.
REQ-021 BVALID SHALL rise the cycle after commit and hold until BVALID&&BREADY; BRESP SHALL be OKAY (00) unless REQ-031 applies.
REQ-022 A write to a RO_MASK register SHALL leave slv_reg unchanged and respond OKAY.
REQ-023 ARREADY SHALL be 1 iff RVALID=0 or RREADY=1 (one-deep read pipeline, no bubble under continuous RREADY).
REQ-024 On AR handshake, RDATA SHALL load slv_read[index] and RVALID SHALL assert the next cycle; RDATA/RVALID hold stable until RREADY.
REQ-025 rd_pulse[index] SHALL be 1 in the cycle after AR handshake for in-range index.
REQ-026 Out-of-range reads SHALL return RDATA=0; out-of-range writes SHALL change no register and pulse nothing.
REQ-027 Read and write on the same register in the same cycle SHALL return slv_read sampled at the AR handshake edge (pre-write).
REQ-028 Read and write paths SHALL be fully independent; neither stalls the other.

Reset
REQ-029 While S_AXI_ARESETN=0: AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse, rd_pulse = 0; BRESP, RRESP, RDATA = 0; holders empty; slv_reg = RST_VAL.
REQ-030 Ready outputs SHALL rise on the first clock edge after deassertion; a transaction in flight at reset assertion SHALL be discarded without response.

Configuration
REQ-031 With macro REGBANK_SLVERR_EN defined, out-of-range accesses SHALL respond SLVERR (10) on BRESP/RRESP; without it they SHALL respond OKAY; data behaviour per REQ-026 either way.

Verification
REQ-032 Write 0x12345678 to addr 0x08, WSTRB=0xF, AW before W by 3 cycles -> slv_reg[2]=0x12345678, wr_pulse[2] one cycle, BRESP=00.
REQ-033 Write 0xFFFFFFFF to 0x0C with WSTRB=0x5 over slv_reg[3]=0 -> slv_reg[3]=0x00FF00FF.
REQ-034 RO_MASK bit 1 set, write 0xAAAA5555 to 0x04 -> slv_reg[1]=RST_VAL[1], BRESP=00, wr_pulse[1] one cycle.
REQ-035 Back-to-back reads 0x00,0x04 with RREADY=1, slv_read[0]=0xDEADBEEF, slv_read[1]=0x76543210 -> consecutive-cycle RVALID with those data; then read 0x3C with NREGS=8 -> RDATA=0, RRESP=10 with REGBANK_SLVERR_EN else 00.
REQ-036 BREADY held low 10 cycles after a write, second AW/W issued -> second commit waits until first B handshake; reset asserted mid-wait -> all outputs 0, slv_reg=RST_VAL.
